// File: rtl/req_seq_pkg.sv
// req_seq_pkg: shared state encoding and default parameters for the request sequencer.
package req_seq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} req_seq_state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TIMEOUT = 8;
  localparam int DEF_MAX_RETRY = 2;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous FIFO with occupancy count; head is the oldest entry.
module req_fifo
  import req_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
endmodule

// File: rtl/req_seq_property.sv
// req_seq_property: bindable checks on the sequencer's req/gnt handshake and ready flag.
module req_seq_property (
  input logic clk,
  input logic rst_n,
  input logic req,
  input logic gnt,
  input logic out_valid,
  input logic in_ready,
  input logic full
);
  a_req_pulse: assert property (@(posedge clk) disable iff (!rst_n) req |=> !req);
  a_out_after_gnt: assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> $past(gnt));
  a_ready_not_full: assert property (@(posedge clk) disable iff (!rst_n) in_ready == !full);
endmodule

// File: rtl/req_sequencer.sv
// req_sequencer: buffers jobs and issues one req pulse per job, retiring on gnt
// or retrying/dropping after a bounded wait.
module req_sequencer
  import req_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   req,
  input  logic                   gnt,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   drop_err,
  output logic                   spurious_gnt,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);
  req_seq_state_t state, nxt;
  logic [TW-1:0] wcnt;
  logic [RW-1:0] retry;
  logic [DATA_W-1:0] head;
  logic push, pop, full, empty, avail, grant, expire, drop;
  assign push = in_valid && in_ready;
  assign in_ready = !full;
  // a push in this cycle counts as work so an idle FSM issues req the next cycle
  assign avail = !empty || push;
  req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .data(in_data),
    .full(full),
    .empty(empty),
    .count(pending),
    .head(head)
  );
  always_comb begin
    grant = state == WAIT && gnt;
    expire = state == WAIT && !gnt && wcnt == TW'(TIMEOUT - 1);
    drop = expire && retry >= RW'(MAX_RETRY);
    pop = grant || drop;
    nxt = state == IDLE ? (avail ? REQ : IDLE) :
          state == REQ  ? WAIT :
          state == WAIT ? ((grant || expire) ? GAP : WAIT) :
                          (avail ? REQ : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      retry <= '0;
      req <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      drop_err <= 1'b0;
      spurious_gnt <= 1'b0;
    end else begin
      state <= nxt;
      wcnt <= state == WAIT ? wcnt + TW'(1) : '0;
      retry <= pop ? '0 : expire ? retry + RW'(1) : retry;
      req <= nxt == REQ;
      out_valid <= grant;
      if (grant) out_data <= head;
      drop_err <= drop;
      spurious_gnt <= gnt && state != WAIT;
    end
endmodule

// File: tb/tb_req_sequencer.sv
// tb_req_sequencer: randomized jobs and grant responder checked against a
// job-level timeline model; granted/dropped jobs are scoreboarded.
module tb_req_sequencer;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;
  localparam int MAX_RETRY = 2;

  logic clk = 0, rst_n = 0, in_valid = 0, gnt = 0;
  logic [DATA_W-1:0] in_data = 0, out_data;
  logic in_ready, req, out_valid, drop_err, spurious_gnt;
  logic [$clog2(DEPTH):0] pending;

  always #5 clk = ~clk;

  req_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .drop_err(drop_err),
    .spurious_gnt(spurious_gnt), .pending(pending)
  );

  req_seq_property u_prop (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .out_valid(out_valid),
    .in_ready(in_ready), .full(pending == 3'(DEPTH))
  );

  typedef struct {bit drop; logic [DATA_W-1:0] data; int cyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [DATA_W-1:0] mq[$];
  int checks = 0, errors = 0, cyc = 0;
  bit busy = 0, exp_spur = 0, found;
  int ready_at = 0, req_cyc = 0, k = 0, attempts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // grant delay after req for one issue; 0 means never grant
  function automatic int pick(input int mode);
    case (mode)
      1: return int'($urandom_range(1, TIMEOUT));
      2: return ($urandom_range(3) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0;
      3: return 1;
      4: return ($urandom_range(1) == 0) ? TIMEOUT : 0;
      default: return 0;
    endcase
  endfunction

  // one cycle of the reference timeline, called at the negedge
  task automatic step(input int push_pct, input int mode, input int spur_pct);
    int n0, w;
    bit exp_req, in_win, g;
    n0 = mq.size();
    chk("pending", int'(pending), n0);
    chk("in_ready", int'(in_ready), int'(n0 < DEPTH));
    chk("spurious_gnt", int'(spurious_gnt), int'(exp_spur));
    exp_req = !busy && cyc >= ready_at && n0 > 0;
    chk("req", int'(req), int'(exp_req));
    if (exp_req) begin
      busy = 1;
      req_cyc = cyc;
      attempts++;
      k = pick(mode);
    end
    in_win = busy && cyc > req_cyc;
    w = cyc - req_cyc;
    g = in_win ? (w == k) : ($urandom_range(99) < spur_pct);
    gnt = g;
    exp_spur = g && !in_win;
    if (in_win && (g || w == TIMEOUT)) begin
      if (g || attempts > MAX_RETRY) begin
        sb.push_back(exp_t'{!g, mq[0], cyc + 1});
        void'(mq.pop_front());
        attempts = 0;
      end
      busy = 0;
      ready_at = cyc + 2;
    end
    in_valid = $urandom_range(99) < push_pct;
    in_data = DATA_W'($urandom);
    if (in_valid && n0 < DEPTH) mq.push_back(in_data);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: expected %s at cycle %0d, still absent at %0d",
                 sb[0].drop ? "drop_err" : "out_valid", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (out_valid || drop_err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event at cycle %0d: out_valid=%0d drop_err=%0d, none expected",
                   cyc, out_valid, drop_err);
        end else begin
          mon_e = sb.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("ev_drop_err", int'(drop_err), int'(mon_e.drop));
          chk("ev_out_valid", int'(out_valid), int'(!mon_e.drop));
          if (!mon_e.drop) chk("out_data", int'(out_data), int'(mon_e.data));
        end
      end
    end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", int'(req), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_drop_err", int'(drop_err), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1;
    step(60, 1, 10);
    repeat (200) begin @(negedge clk); step(60, 1, 10); end
    repeat (300) begin @(negedge clk); step(30, 2, 8); end
    repeat (60) begin @(negedge clk); step(100, 0, 5); end
    repeat (150) begin @(negedge clk); step(80, 3, 8); end
    repeat (200) begin @(negedge clk); step(40, 4, 8); end
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      step(90, 0, 0);
      found = busy && cyc > req_cyc && mq.size() >= 3;
    end
    chk("reset_setup", int'(found), 1);
    #2 rst_n = 0;
    in_valid = 0;
    gnt = 0;
    #1;
    chk("async_rst_req", int'(req), 0);
    chk("async_rst_pending", int'(pending), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    mq.delete();
    sb.delete();
    busy = 0;
    ready_at = 0;
    attempts = 0;
    exp_spur = 0;
    rst_n = 1;
    step(0, 1, 0);
    repeat (20) begin @(negedge clk); step(0, 1, 0); end
    repeat (100) begin @(negedge clk); step(50, 1, 8); end
    repeat (150) begin @(negedge clk); step(0, 1, 0); end
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_pending", int'(pending), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/req_sequencer.md
# req_sequencer

Upstream stage for the req/gnt grant block (`dut`). It accepts jobs over a valid/ready input, buffers them in a small FIFO, and issues one single-cycle `req` pulse per job. It then waits a bounded time for `gnt`. It retires the job on grant, and retries or drops it on timeout. Its `req`/`gnt` pair connects directly to `dut.req`/`dut.gnt`.

## Interface
- `DATA_W`, 8, job payload width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `TIMEOUT`, 8, max cycles after the `req` pulse to wait for `gnt` (≥2)
- `MAX_RETRY`, 2, re-issues allowed after the first timeout before the job is dropped
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  job offered
- `in_data`  in  DATA_W  job payload
- `in_ready`  out  1  FIFO can accept (= not full)
- `req`  out  1  registered request pulse to grant block
- `gnt`  in  1  grant from grant block
- `out_valid`  out  1  one-cycle pulse: job granted
- `out_data`  out  DATA_W  payload of granted job, valid with `out_valid`
- `drop_err`  out  1  one-cycle pulse: job dropped after retries exhausted
- `spurious_gnt`  out  1  one-cycle pulse: `gnt` seen outside WAIT
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: the FIFO writes on `in_valid && in_ready`. A push while full is impossible because `in_ready` is 0.
- FSM states: IDLE, REQ, WAIT, GAP.
  - IDLE: `req`=0. Goes to REQ when the FIFO is non-empty.
  - REQ: `req`=1 for exactly one cycle. Clears the wait counter. Always goes to WAIT.
  - WAIT: `req`=0. The counter increments each cycle.
    - `gnt`=1: pop the head, pulse `out_valid` with the head data, clear the retry count, go to GAP.
    - Counter reaches TIMEOUT with no `gnt`:
      - If retry count < MAX_RETRY: increment it and go to GAP (the head is kept and re-issued).
      - Otherwise: pop the head, pulse `drop_err`, clear the retry count, go to GAP.
  - GAP: one cycle with `req`=0, which guarantees a low cycle between pulses. Then goes to IDLE, or directly to REQ if the FIFO is non-empty after the pop.
- `gnt` in any state other than WAIT: `spurious_gnt` pulses and the FSM is unaffected.
- Push and pop in the same cycle: both happen and `pending` is unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Full is defined as count == DEPTH.

## Timing
- Reset values:
  - state = IDLE
  - `req`, `out_valid`, `drop_err`, `spurious_gnt` = 0
  - `out_data` = 0
  - `pending` = 0 and `in_ready` = 1
  - pointers, counters and retry count = 0
- Reset asserted mid-operation: all queued jobs are discarded immediately and there is no `out_valid` for them.
- Cycle timing, with an empty FIFO in IDLE:
  - Push at cycle N → `pending`=1 at N+1.
  - FSM is in REQ at N+1, so `req` is high during cycle N+1 (registered output).
- Grant timing:
  - `gnt` sampled high k cycles after the `req` cycle (1 ≤ k ≤ TIMEOUT) → `out_valid` high in the following cycle.
  - Back-to-back jobs therefore have `req` edges at least 3 cycles apart (REQ, WAIT ≥1, GAP).
- `gnt` sampled in the same cycle that the counter reaches TIMEOUT counts as a grant; grant has priority over timeout.
- `in_ready` is combinational from occupancy and is independent of `in_valid`.

## Structure
- Package `req_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} req_seq_state_t`
  - default parameter constants.
- Sub-module `req_fifo`: synchronous FIFO with parameters DATA_W and DEPTH; ports push/pop/full/empty/count/head.
- The FSM, counters and error pulses live in `req_sequencer`.
- A bindable property module `req_seq_property` checks the following:
  - `req` is never high for two consecutive cycles.
  - `out_valid` implies `gnt` was high in the previous cycle.
  - `in_ready` == !full.

## Test plan
- Single job: push 0x5A; grant 2 cycles after `req` → one `req` pulse, `out_valid`=1 with `out_data`=0x5A, `pending` returns to 0.
- Fill: 4 pushes with `gnt` tied 0 until the FIFO is full → `in_ready`=0 and `pending`=4. A 5th push is held off. Then grant each job on its first WAIT cycle → data comes out in order.
- Timeout/retry (TIMEOUT=8, MAX_RETRY=2): never grant → 3 `req` pulses, then `drop_err` after the 3rd timeout, and the next job is issued.
- Retry success: no grant on the 1st issue, grant on the 2nd → one `out_valid` and no `drop_err`.
- Spurious grant: `gnt`=1 in IDLE → `spurious_gnt` pulses, and there is no pop and no `out_valid`.
- Reset mid-WAIT with 3 jobs queued: assert `rst_n`=0 asynchronously → `req`=0, `pending`=0, `in_ready`=1 immediately, and no `out_valid` after release.
